lock_sequencer: RTL and testbench
=================================

LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 Parameter T_GATE, default 10'd300, gate-open dwell in seconds (5 min).
REQ-002 Parameter T_FILL, default 10'd420, chamber fill time in seconds (7 min).
REQ-003 Parameter T_DRAIN, default 10'd480, chamber drain time in seconds (8 min).
REQ-004 clk  input  1  single clock, 1 Hz in system; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 arrive_lo  input  1  one-cycle pulse: boat at low-water gate requests passage up.
REQ-007 arrive_hi  input  1  one-cycle pulse: boat at high-water gate requests passage down.
REQ-008 timer_done  input  1  countdown timer expired (high while timer count is zero).
REQ-009 timer_reset  output  1  loads timer with timer_seconds and disarms it.
REQ-010 timer_start  output  1  one-cycle arm pulse to timer.
REQ-011 timer_seconds  output  10  countdown length for current timed phase.
REQ-012 gate_lo_open, gate_hi_open, fill_valve, drain_valve  output  1 each  actuator commands.
REQ-013 level_high  output  1  chamber water level: 1 high, 0 low.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 trip_done  output  1  one-cycle pulse when a passage completes.

Function
REQ-016 Main states SHALL be IDLE, DRAIN, GATE_LO, FILL, GATE_HI; each non-IDLE state SHALL have sub-phases LOAD, ARM, RUN.
REQ-017 LOAD (1 cycle): timer_reset=1, timer_seconds=phase constant (GATE_*: T_GATE, FILL: T_FILL, DRAIN: T_DRAIN); ARM (1 cycle): timer_start=1; RUN: wait for timer_done=1, then next main state's LOAD on following cycle.
REQ-018 timer_done SHALL be ignored in LOAD and ARM; timer_seconds SHALL hold its phase constant through LOAD, ARM, RUN.
REQ-019 Pulses on arrive_lo/arrive_hi SHALL set pending bits pend_up/pend_dn in any state; a bit SHALL clear only on the cycle IDLE launches its service; repeat pulses while pending SHALL merge.
REQ-020 From IDLE with pend_up: level_high=1 -> DRAIN; level_high=0 -> GATE_LO. Up sequence: [DRAIN] -> GATE_LO -> FILL -> GATE_HI -> IDLE.
REQ-021 From IDLE with pend_dn: level_high=0 -> FILL; level_high=1 -> GATE_HI. Down sequence: [FILL] -> GATE_HI -> DRAIN -> GATE_LO -> IDLE.
REQ-022 Both pending in IDLE: serve the direction needing no level change (pend_dn if level_high=1, pend_up if 0).
REQ-023 Direction of the active trip SHALL be held in a register for sequencing; FILL SHALL set level_high=1 and DRAIN SHALL set level_high=0 on RUN exit.
REQ-024 Actuators SHALL be registered and asserted only during the matching state (all sub-phases): gate_lo_open in GATE_LO, gate_hi_open in GATE_HI, fill_valve in FILL, drain_valve in DRAIN.
REQ-025 At most one actuator SHALL be high in any cycle; gate_lo_open SHALL never be high with level_high=1, gate_hi_open never with level_high=0.
REQ-026 trip_done SHALL pulse on the cycle of return to IDLE; IDLE with a pending bit SHALL launch on the next cycle (one IDLE cycle minimum between trips).
REQ-027 An arrive pulse coinciding with trip_done SHALL be latched, not lost.

Reset
REQ-028 While reset=1: state=IDLE, sub-phase=LOAD, pend_up=pend_dn=0, level_high=0, all actuators 0, timer_start=0, trip_done=0, busy=0, timer_seconds=0, timer_reset=1.
REQ-029 Reset asserted mid-trip SHALL abort immediately (next edge) with all actuators closed and pending requests discarded.

Verification (T_GATE=3, T_FILL=4, T_DRAIN=5, model timer attached)
REQ-030 Reset release, pulse arrive_lo -> GATE_LO (gate_lo_open 3 s), FILL 4 s, GATE_HI 3 s, trip_done pulse, level_high=1, busy=0.
REQ-031 level_high=1, pulse arrive_lo -> DRAIN first with timer_seconds=5, then GATE_LO/FILL/GATE_HI; level_high ends 1.
REQ-032 level_high=0, arrive_lo and arrive_hi same cycle -> up trip first; then down trip (GATE_HI, DRAIN, GATE_LO) starts one cycle after trip_done.
REQ-033 arrive_hi pulsed during FILL of up trip and again on trip_done cycle -> exactly one down trip follows.
REQ-034 reset asserted during FILL RUN -> next cycle all actuators 0, level_high=0, timer_reset=1, no trip_done.
REQ-035 Every cycle of all runs: actuator one-hot-or-zero and gate/level interlock (REQ-025) checked by assertion.

Source files
------------

// File: rtl/lock_sequencer.sv
// Canal lock passage sequencer: serves up/down boat requests by stepping gates and
// valves through timed phases, driving an external countdown timer per phase.
module lock_sequencer #(
  parameter logic [9:0] T_GATE  = 10'd300,
  parameter logic [9:0] T_FILL  = 10'd420,
  parameter logic [9:0] T_DRAIN = 10'd480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arrive_lo,
  input  logic       arrive_hi,
  input  logic       timer_done,
  output logic       timer_reset,
  output logic       timer_start,
  output logic [9:0] timer_seconds,
  output logic       gate_lo_open,
  output logic       gate_hi_open,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       level_high,
  output logic       busy,
  output logic       trip_done
);

  typedef enum logic [2:0] {IDLE, DRAIN, GATE_LO, FILL, GATE_HI} state_t;
  typedef enum logic [1:0] {LOAD, ARM, RUN} phase_t;

  state_t state_r, state_nx_s;
  phase_t phase_r, phase_nx_s;
  logic   dir_up_r, dir_up_nx_s;
  logic   pend_up_r, pend_dn_r;
  logic   launch_up_s, launch_dn_s;
  logic   level_nx_s, done_nx_s;

  // Up trips end by opening the high gate, down trips by opening the low gate.
  function automatic state_t next_main(input state_t cur, input logic up);
    state_t nx;
    case (cur)
      DRAIN:   nx = GATE_LO;
      GATE_LO: nx = up ? FILL : IDLE;
      FILL:    nx = GATE_HI;
      GATE_HI: nx = up ? IDLE : DRAIN;
      default: nx = IDLE;
    endcase
    return nx;
  endfunction

  function automatic logic [9:0] phase_secs(input state_t st);
    logic [9:0] s;
    case (st)
      GATE_LO, GATE_HI: s = T_GATE;
      FILL:             s = T_FILL;
      DRAIN:            s = T_DRAIN;
      default:          s = 10'd0;
    endcase
    return s;
  endfunction

  // Next-state decision: request arbitration in IDLE, LOAD/ARM/RUN stepping elsewhere.
  always_comb begin
    state_nx_s  = state_r;
    phase_nx_s  = phase_r;
    dir_up_nx_s = dir_up_r;
    launch_up_s = 1'b0;
    launch_dn_s = 1'b0;
    level_nx_s  = level_high;
    done_nx_s   = 1'b0;
    case (state_r)
      IDLE: begin
        phase_nx_s = LOAD;
        // With both pending, favour the direction that needs no level change.
        if (pend_up_r && (!pend_dn_r || !level_high)) begin
          launch_up_s = 1'b1;
          dir_up_nx_s = 1'b1;
          state_nx_s  = level_high ? DRAIN : GATE_LO;
        end else if (pend_dn_r) begin
          launch_dn_s = 1'b1;
          dir_up_nx_s = 1'b0;
          state_nx_s  = level_high ? GATE_HI : FILL;
        end else begin
          state_nx_s = IDLE;
        end
      end
      DRAIN, GATE_LO, FILL, GATE_HI: begin
        case (phase_r)
          LOAD: phase_nx_s = ARM;
          ARM:  phase_nx_s = RUN;
          RUN: begin
            if (timer_done) begin
              if (state_r == FILL) begin
                level_nx_s = 1'b1;
              end else if (state_r == DRAIN) begin
                level_nx_s = 1'b0;
              end else begin
                level_nx_s = level_high;
              end
              state_nx_s = next_main(state_r, dir_up_r);
              phase_nx_s = LOAD;
              done_nx_s  = (next_main(state_r, dir_up_r) == IDLE);
            end else begin
              phase_nx_s = RUN;
            end
          end
          default: phase_nx_s = LOAD;
        endcase
      end
      default: begin
        state_nx_s = IDLE;
        phase_nx_s = LOAD;
      end
    endcase
  end

  // State, request latches and registered outputs aligned with the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      phase_r       <= LOAD;
      dir_up_r      <= 1'b0;
      pend_up_r     <= 1'b0;
      pend_dn_r     <= 1'b0;
      level_high    <= 1'b0;
      gate_lo_open  <= 1'b0;
      gate_hi_open  <= 1'b0;
      fill_valve    <= 1'b0;
      drain_valve   <= 1'b0;
      timer_reset   <= 1'b1;
      timer_start   <= 1'b0;
      timer_seconds <= 10'd0;
      busy          <= 1'b0;
      trip_done     <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      phase_r       <= phase_nx_s;
      dir_up_r      <= dir_up_nx_s;
      pend_up_r     <= (pend_up_r | arrive_lo) & ~launch_up_s;
      pend_dn_r     <= (pend_dn_r | arrive_hi) & ~launch_dn_s;
      level_high    <= level_nx_s;
      gate_lo_open  <= (state_nx_s == GATE_LO);
      gate_hi_open  <= (state_nx_s == GATE_HI);
      fill_valve    <= (state_nx_s == FILL);
      drain_valve   <= (state_nx_s == DRAIN);
      timer_reset   <= (phase_nx_s == LOAD);
      timer_start   <= (state_nx_s != IDLE) && (phase_nx_s == ARM);
      timer_seconds <= phase_secs(state_nx_s);
      busy          <= (state_nx_s != IDLE);
      trip_done     <= done_nx_s;
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with a model countdown timer; phase starts and
// trip completions are matched against a scoreboard of expected events.
module tb_lock_sequencer;

  localparam int TG = 3;
  localparam int TF = 4;
  localparam int TD = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       arrive_lo = 1'b0;
  logic       arrive_hi = 1'b0;
  logic       timer_done;
  logic       timer_reset, timer_start;
  logic [9:0] timer_seconds;
  logic       gate_lo_open, gate_hi_open, fill_valve, drain_valve;
  logic       level_high, busy, trip_done;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  logic [9:0] cnt_r = 10'd0;
  logic       armed_r = 1'b0;
  logic [3:0] act_s, act_prev_r;
  int         run_len = 0;

  lock_sequencer #(.T_GATE(10'd3), .T_FILL(10'd4), .T_DRAIN(10'd5)) dut (
    .clk(clk), .reset(reset), .arrive_lo(arrive_lo), .arrive_hi(arrive_hi),
    .timer_done(timer_done), .timer_reset(timer_reset), .timer_start(timer_start),
    .timer_seconds(timer_seconds), .gate_lo_open(gate_lo_open), .gate_hi_open(gate_hi_open),
    .fill_valve(fill_valve), .drain_valve(drain_valve), .level_high(level_high),
    .busy(busy), .trip_done(trip_done)
  );

  always #5 clk = ~clk;

  // Countdown timer model: load+disarm on timer_reset, arm on timer_start.
  always @(posedge clk) begin
    if (timer_reset) begin
      cnt_r   <= timer_seconds;
      armed_r <= 1'b0;
    end else if (timer_start) begin
      armed_r <= 1'b1;
    end else if (armed_r && cnt_r != 10'd0) begin
      cnt_r <= cnt_r - 10'd1;
    end
  end
  assign timer_done = (cnt_r == 10'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ev_phase(input logic [3:0] act, input logic [9:0] secs);
    return {2'b01, act, secs};
  endfunction

  function automatic logic [15:0] ev_trip(input logic lvl);
    return {2'b10, 13'd0, lvl};
  endfunction

  function automatic int exp_len(input logic [3:0] a);
    case (a)
      4'b1000, 4'b0010: return TG + 3;
      4'b0100:          return TF + 3;
      4'b0001:          return TD + 3;
      default:          return 0;
    endcase
  endfunction

  task automatic sb_pop(input string tag, input logic [15:0] got);
    chk({tag, "_expected"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) chk(tag, 32'(got), 32'(exp_q.pop_front()));
  endtask

  // act order: {gate_lo, fill, gate_hi, drain}
  task automatic push_up(input logic lvl);
    if (lvl) exp_q.push_back(ev_phase(4'b0001, 10'(TD)));
    exp_q.push_back(ev_phase(4'b1000, 10'(TG)));
    exp_q.push_back(ev_phase(4'b0100, 10'(TF)));
    exp_q.push_back(ev_phase(4'b0010, 10'(TG)));
    exp_q.push_back(ev_trip(1'b1));
  endtask

  task automatic push_dn(input logic lvl);
    if (!lvl) exp_q.push_back(ev_phase(4'b0100, 10'(TF)));
    exp_q.push_back(ev_phase(4'b0010, 10'(TG)));
    exp_q.push_back(ev_phase(4'b0001, 10'(TD)));
    exp_q.push_back(ev_phase(4'b1000, 10'(TG)));
    exp_q.push_back(ev_trip(1'b0));
  endtask

  // Per-cycle monitor: interlocks, scoreboard events and actuator dwell times.
  always @(negedge clk) begin
    act_s = {gate_lo_open, fill_valve, gate_hi_open, drain_valve};
    if (reset) begin
      act_prev_r = 4'b0;
      run_len = 0;
    end else begin
      chk("onehot0", 32'($onehot0(act_s)), 32'd1);
      chk("interlock", 32'((gate_lo_open & level_high) | (gate_hi_open & ~level_high)), 32'd0);
      if (busy && timer_reset) sb_pop("phase", ev_phase(act_s, timer_seconds));
      if (trip_done) sb_pop("trip", ev_trip(level_high));
      if (act_s != act_prev_r) begin
        if (act_prev_r != 4'b0) chk("dwell", 32'(run_len), 32'(exp_len(act_prev_r)));
        run_len = 1;
      end else begin
        run_len++;
      end
      act_prev_r = act_s;
    end
  end

  task automatic pulse(input logic lo, input logic hi);
    arrive_lo = lo;
    arrive_hi = hi;
    @(negedge clk);
    arrive_lo = 1'b0;
    arrive_hi = 1'b0;
  endtask

  // which: 0 = fill_valve, 1 = trip_done
  task automatic wait_sig(input int which, input int budget);
    int n = 0;
    @(negedge clk);
    while (((which == 0) ? !fill_valve : !trip_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_sig_timeout", 32'(n >= budget), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", 32'(n >= budget), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({gate_lo_open, gate_hi_open, fill_valve, drain_valve, timer_start,
                              trip_done, busy, level_high, timer_reset}), 32'b000000001);
    chk("reset_seconds", 32'(timer_seconds), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'({busy, level_high}), 32'd0);

    // Up trip from low water.
    push_up(1'b0);
    pulse(1'b1, 1'b0);
    wait_idle(200);
    chk("up_low_level", 32'({level_high, busy}), 32'b10);

    // Up trip from high water starts by draining.
    push_up(1'b1);
    pulse(1'b1, 1'b0);
    wait_idle(200);
    chk("up_high_level", 32'(level_high), 32'd1);

    // Down trip from high water.
    push_dn(1'b1);
    pulse(1'b0, 1'b1);
    wait_idle(200);
    chk("down_high_level", 32'(level_high), 32'd0);

    // Simultaneous requests at low water: up first, down launches right after trip_done.
    push_up(1'b0);
    push_dn(1'b1);
    pulse(1'b1, 1'b1);
    wait_sig(1, 200);
    @(negedge clk);
    chk("back_to_back_launch", 32'({busy, gate_hi_open, timer_reset}), 32'b111);
    wait_idle(200);

    // Repeat down requests during FILL and on trip_done merge into one down trip.
    push_up(1'b0);
    push_dn(1'b1);
    pulse(1'b1, 1'b0);
    wait_sig(0, 200);
    pulse(1'b0, 1'b1);
    wait_sig(1, 200);
    pulse(1'b0, 1'b1);
    chk("merge_launch", 32'({busy, gate_hi_open}), 32'b11);
    wait_idle(200);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("merge_no_extra", 32'(busy), 32'd0);
    end

    // A request arriving only on the trip_done cycle is still served.
    push_up(1'b0);
    push_dn(1'b1);
    pulse(1'b1, 1'b0);
    wait_sig(1, 200);
    pulse(1'b0, 1'b1);
    wait_idle(200);
    chk("late_req_level", 32'(level_high), 32'd0);

    // Reset during FILL RUN aborts the trip and drops the pending down request.
    exp_q.push_back(ev_phase(4'b1000, 10'(TG)));
    exp_q.push_back(ev_phase(4'b0100, 10'(TF)));
    pulse(1'b1, 1'b0);
    wait_sig(0, 200);
    pulse(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("in_fill_run", 32'({fill_valve, timer_reset, timer_start}), 32'b100);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outputs", 32'({gate_lo_open, gate_hi_open, fill_valve, drain_valve, level_high,
                              timer_reset, trip_done, busy}), 32'b00000100);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_launch", 32'({busy, trip_done}), 32'd0);
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
